// File: rtl/aura_pkg.sv
// Shared attention-datapath constants and element/score types.
package aura_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned LANES    = 4;
  localparam int unsigned CHUNKS   = 16;
  localparam int unsigned HEAD_DIM = LANES * CHUNKS;
  // Wide enough that HEAD_DIM worst-case products can never overflow.
  localparam int unsigned ACC_W    = 2 * DATA_W + $clog2(HEAD_DIM);

  typedef logic signed [DATA_W-1:0] elem_t;
  typedef logic signed [ACC_W-1:0]  score_t;

endpackage

// File: rtl/vec_dot.sv
// Combinational LANES-wide signed multiply and adder tree for one Q/K beat.
module vec_dot #(
  parameter int unsigned LANES  = aura_pkg::LANES,
  parameter int unsigned DATA_W = aura_pkg::DATA_W,
  parameter int unsigned ACC_W  = aura_pkg::ACC_W
) (
  input  logic [LANES*DATA_W-1:0] q_i,
  input  logic [LANES*DATA_W-1:0] k_i,
  output logic [ACC_W-1:0]        beat_sum_o
);

  import aura_pkg::*;

  logic signed [2*DATA_W-1:0] prod [LANES];
  logic signed [ACC_W-1:0]    sum;

  // Full-precision lane products, sign-extended into the accumulator width.
  always_comb begin
    sum = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      prod[i] = $signed(q_i[i*DATA_W +: DATA_W]) * $signed(k_i[i*DATA_W +: DATA_W]);
      sum     = sum + ACC_W'(prod[i]);
    end
  end

  assign beat_sum_o = sum;

endmodule

// File: rtl/qk_dot_stage.sv
// Accumulates CHUNKS beats of Q.K lane products into one score and holds it
// until the downstream handshake register takes it.
module qk_dot_stage #(
  parameter int unsigned LANES  = aura_pkg::LANES,
  parameter int unsigned CHUNKS = aura_pkg::CHUNKS,
  parameter int unsigned DATA_W = aura_pkg::DATA_W,
  parameter int unsigned ACC_W  = 2 * DATA_W + $clog2(LANES * CHUNKS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    vld_in,
  output logic                    rdy_out,
  input  logic [LANES*DATA_W-1:0] q_in,
  input  logic [LANES*DATA_W-1:0] k_in,
  output logic                    vld_out,
  input  logic                    rdy_in,
  output logic [ACC_W-1:0]        score_out,
  output logic [15:0]             row_cnt
);

  import aura_pkg::*;

  localparam int unsigned CntW      = $clog2(CHUNKS);
  localparam logic [CntW-1:0] LastChunk = CntW'(CHUNKS - 1);

  localparam logic [0:0] StAccum = 1'b0;
  localparam logic [0:0] StHold  = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CntW-1:0] chunk_q, chunk_d;
  logic [ACC_W-1:0] score_q, score_d;
  logic [15:0]     row_cnt_q, row_cnt_d;
  logic [ACC_W-1:0] beat_sum;
  logic            accept;
  logic            deliver;

  vec_dot #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_vec_dot (
    .q_i        (q_in),
    .k_i        (k_in),
    .beat_sum_o (beat_sum)
  );

  // Ready depends only on state and downstream ready, never on vld_in.
  always_comb begin
    rdy_out = (state_q == StAccum) ? 1'b1 : rdy_in;
    vld_out = (state_q == StHold);
    accept  = vld_in & rdy_out;
    deliver = vld_out & rdy_in;
  end

  // Next-state: accumulate beats, close the row on the last chunk, release on delivery.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    chunk_d   = chunk_q;
    score_d   = score_q;
    row_cnt_d = row_cnt_q;
    if (deliver) begin
      state_d   = StAccum;
      row_cnt_d = row_cnt_q + 16'd1;
    end
    // In HOLD acc and chunk are zero, so an overlapping beat starts the next row.
    if (accept) begin
      if (chunk_q == LastChunk) begin
        score_d = acc_q + beat_sum;
        acc_d   = '0;
        chunk_d = '0;
        state_d = StHold;
      end else begin
        acc_d   = acc_q + beat_sum;
        chunk_d = chunk_q + CntW'(1);
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StAccum;
      acc_q     <= '0;
      chunk_q   <= '0;
      score_q   <= '0;
      row_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      chunk_q   <= chunk_d;
      score_q   <= score_d;
      row_cnt_q <= row_cnt_d;
    end
  end

  assign score_out = score_q;
  assign row_cnt   = row_cnt_q;

endmodule

// File: tb/tb_qk_dot_stage.sv
// Scoreboard bench for qk_dot_stage: stimulus side predicts scores, monitor checks deliveries.
module tb_qk_dot_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld_in;
  logic        rdy_out;
  logic [31:0] q_in;
  logic [31:0] k_in;
  logic        vld_out;
  logic        rdy_in;
  logic [21:0] score_out;
  logic [15:0] row_cnt;

  qk_dot_stage dut (
    .clk       (clk),
    .rst       (rst),
    .vld_in    (vld_in),
    .rdy_out   (rdy_out),
    .q_in      (q_in),
    .k_in      (k_in),
    .vld_out   (vld_out),
    .rdy_in    (rdy_in),
    .score_out (score_out),
    .row_cnt   (row_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];
  int mon_rows = 0;

  // Reference model state: pending score, partial row sum, beats in row.
  bit m_pend = 0;
  int m_acc  = 0;
  int m_cnt  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dot(input logic [31:0] q, input logic [31:0] k);
    int s = 0;
    for (int i = 0; i < 4; i++)
      s += int'($signed(q[i*8 +: 8])) * int'($signed(k[i*8 +: 8]));
    return s;
  endfunction

  function automatic logic [31:0] splat(input int v);
    logic [7:0] b;
    b = v[7:0];
    return {b, b, b, b};
  endfunction

  // One clock of stimulus; model decides acceptance from its own notion of readiness.
  task automatic step(input logic [31:0] q, input logic [31:0] k, input logic v, input logic r);
    bit m_rdy;
    vld_in = v;
    q_in   = q;
    k_in   = k;
    rdy_in = r;
    @(negedge clk);
    m_rdy = !m_pend || r;
    check("rdy_out", int'(rdy_out), int'(m_rdy));
    check("vld_out", int'(vld_out), int'(m_pend));
    if (m_pend && r) m_pend = 0;
    if (v && m_rdy) begin
      m_acc += dot(q, k);
      m_cnt++;
      if (m_cnt == 16) begin
        exp_q.push_back(m_acc);
        m_pend = 1;
        m_acc  = 0;
        m_cnt  = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic row(input int qv, input int kv);
    for (int i = 0; i < 16; i++) step(splat(qv), splat(kv), 1'b1, 1'b1);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    vld_in = 1'b0;
    rdy_in = 1'b0;
    exp_q.delete();
    mon_rows = 0;
    m_pend = 0;
    m_acc  = 0;
    m_cnt  = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  // Monitor: score must match the queue head while valid; pop on delivery.
  always @(negedge clk) begin
    if (!rst) begin
      logic signed [21:0] s;
      s = score_out;
      check("row_cnt", int'(row_cnt), mon_rows);
      if (vld_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_vld_out", 1, 0);
        end else begin
          check("score_out", int'(s), exp_q[0]);
          if (rdy_in) begin
            void'(exp_q.pop_front());
            mon_rows++;
          end
        end
      end
    end
  end

  initial begin
    rst    = 1'b1;
    vld_in = 1'b0;
    rdy_in = 1'b0;
    q_in   = '0;
    k_in   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_rdy_out", int'(rdy_out), 1);
    check("reset_vld_out", int'(vld_out), 0);
    check("reset_score", int'(score_out), 0);
    check("reset_row_cnt", int'(row_cnt), 0);
    @(posedge clk);
    #1;

    // Basic row, extreme values, then two back-to-back rows with no stall.
    row(1, 1);
    idle(2);
    check("row_cnt_after_first", int'(row_cnt), 1);
    row(-128, -128);
    row(-128, 127);
    row(2, 2);
    row(3, -1);
    idle(2);

    // Backpressure: hold for 5 cycles with data offered, then overlap delivery with chunk 0.
    for (int i = 0; i < 15; i++) step(splat(1), splat(1), 1'b1, 1'b1);
    step(splat(1), splat(1), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(splat(7), splat(9), 1'b1, 1'b0);
    row(1, 1);
    idle(2);

    // Mid-row reset discards the partial sum.
    for (int i = 0; i < 7; i++) step(splat(5), splat(5), 1'b1, 1'b1);
    do_reset();
    row(1, 2);
    idle(2);

    // Bubbles every other cycle.
    for (int i = 0; i < 32; i++) step(splat(1), splat(1), 1'(i % 2 == 0), 1'b1);
    idle(2);

    // Reset while holding an undelivered score.
    for (int i = 0; i < 16; i++) step(splat(4), splat(4), 1'b1, 1'b0);
    step(32'h0, 32'h0, 1'b0, 1'b0);
    do_reset();
    idle(3);

    // Random traffic with random bubbles and backpressure.
    for (int i = 0; i < 600; i++)
      step($urandom, $urandom, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
    idle(4);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/qk_dot_stage.md
QK_DOT_STAGE -- requirements
Module: qk_dot_stage

Interface
REQ-001 Parameter LANES, default 4: int8 element pairs per input beat.
REQ-002 Parameter CHUNKS, default 16: beats per score row; HEAD_DIM = LANES*CHUNKS; CHUNKS >= 2.
REQ-003 Parameter DATA_W, default 8: signed element width.
REQ-004 Parameter ACC_W, default 2*DATA_W+$clog2(LANES*CHUNKS) (22): signed accumulator and score width.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 vld_in  in  1  upstream beat valid.
REQ-008 rdy_out  out  1  this stage can accept a beat.
REQ-009 q_in  in  LANES*DATA_W  packed signed Q elements; lane i at bits [i*DATA_W +: DATA_W].
REQ-010 k_in  in  LANES*DATA_W  packed signed K elements, same lane packing.
REQ-011 vld_out  out  1  score_out valid.
REQ-012 rdy_in  in  1  downstream (handshake register) ready.
REQ-013 score_out  out  ACC_W  signed Q.K dot product for one row.
REQ-014 row_cnt  out  16  count of scores delivered downstream; wraps 0xFFFF -> 0.

Function
REQ-015 Beat accepted iff vld_in && rdy_out on a clock edge; score delivered iff vld_out && rdy_in.
REQ-016 beat_sum = sum over lanes of sign-extended q[i]*k[i], computed at full precision and extended to ACC_W; no saturation or truncation.
REQ-017 State machine has two states: ACCUM (vld_out=0) and HOLD (vld_out=1).
REQ-018 ACCUM: rdy_out=1; each accepted beat adds beat_sum to acc and increments chunk_cnt (0..CHUNKS-1).
REQ-019 ACCUM, beat accepted with chunk_cnt==CHUNKS-1: score_out<=acc+beat_sum, acc<=0, chunk_cnt<=0, next state HOLD.
REQ-020 Latency: vld_out asserts the cycle after the last beat of a row is accepted.
REQ-021 HOLD: rdy_out=rdy_in (combinational); score_out and vld_out stay stable until delivered.
REQ-022 HOLD with delivery: row_cnt increments and next state is ACCUM; a beat accepted in the same cycle is chunk 0 of the next row.
REQ-023 HOLD without delivery: no beat accepted; acc, chunk_cnt and score_out unchanged.
REQ-024 When vld_in=0, acc and chunk_cnt hold; bubbles anywhere in a row do not affect the result.
REQ-025 q_in/k_in are ignored when no beat is accepted.
REQ-026 rdy_out shall not depend combinationally on vld_in.

Reset
REQ-027 On rst: state=ACCUM, vld_out=0, score_out=0, acc=0, chunk_cnt=0, row_cnt=0.
REQ-028 rdy_out=1 in the cycle after rst deasserts.
REQ-029 Reset mid-row discards the partial acc; the next CHUNKS accepted beats form a fresh row.
REQ-030 Reset while in HOLD drops the pending score without delivery and without incrementing row_cnt.

Structure
REQ-031 DATA_W, LANES, CHUNKS, HEAD_DIM, ACC_W and the typedefs elem_t (signed DATA_W) and score_t (signed ACC_W) are defined in the shared package aura_pkg.
REQ-032 The combinational LANES-wide multiply/adder tree is a sub-module named vec_dot (inputs q/k vectors, output beat_sum).
REQ-033 score_out feeds the downstream handshake register directly: vld_out->vld_in, rdy_in<-rdy_out, score_out->data_in.

Verification (LANES=4, CHUNKS=16, DATA_W=8)
REQ-034 All q=1, k=1, 16 consecutive beats, rdy_in=1 -> score_out=64, vld_out high exactly one cycle after beat 16, row_cnt=1.
REQ-035 All q=-128, k=-128 -> score_out=1048576; all q=-128, k=127 -> score_out=-1040384 (no overflow).
REQ-036 Row complete, rdy_in=0 for 5 cycles with vld_in=1 -> rdy_out=0 and score_out stable for 5 cycles; rdy_in=1 -> score delivered and chunk 0 of the next row accepted in that cycle.
REQ-037 Continuous vld_in and rdy_in for 32 beats with q=k=2 in row 1 and q=3, k=-1 in row 2 -> scores 256 then -192, no stall cycles, row_cnt=2.
REQ-038 rst asserted after 7 beats, then 16 beats of q=1, k=2 -> score_out=128.
REQ-039 vld_in toggling every other cycle over one row of q=1, k=1 -> score_out=64, matching REQ-034.
